// File: rtl/dct_mac_sequencer.sv
`default_nettype none
//============================================================================
// Module : dct_mac_sequencer
// Brief  : Sequences one 8x8 2-D DCT, one coefficient at a time, through a
//          3-stage pipelined MAC with a ready/valid coefficient output.
// Rev    : 1.0  initial release
//============================================================================
module dct_mac_sequencer #(
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [5:0]  pix_addr,
    input  logic [7:0]  pix_data,
    output logic [2:0]  k1,
    output logic [2:0]  k2,
    output logic [2:0]  n1,
    output logic [2:0]  n2,
    input  logic [31:0] cos_term,
    output logic        coef_valid,
    input  logic        coef_ready,
    output logic [5:0]  coef_addr,
    output logic [31:0] coef_data
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_run   = 3'd1;
    localparam logic [2:0] c_st_drain = 3'd2;
    localparam logic [2:0] c_st_out   = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [5:0]         c_last_idx = 6'd63;
    localparam logic signed [47:0] c_sat_max  = 48'sh0000_7FFF_FFFF;
    localparam logic signed [47:0] c_sat_min  = 48'shFFFF_8000_0000;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [5:0]         r_n;
    logic [5:0]         r_k;
    logic               r_drain;
    logic               r_s1_valid;
    logic [31:0]        r_cos;
    logic               r_s2_valid;
    logic [39:0]        r_prod;
    logic signed [47:0] r_acc;
    logic               r_coef_valid;
    logic [5:0]         r_coef_addr;
    logic [31:0]        r_coef_data;

    logic               w_handshake;
    logic               w_start_ok;
    logic [39:0]        w_prod;
    logic signed [47:0] w_acc_next;
    logic signed [47:0] w_shift;
    logic [31:0]        w_sat;

    //------------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    //------------------------------------------------------------------------
    // FSM: next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_next_state = c_st_run;
                end
            end
            c_st_run: begin
                if (r_n == c_last_idx) begin
                    w_next_state = c_st_drain;
                end
            end
            c_st_drain: begin
                if (r_drain) begin
                    w_next_state = c_st_out;
                end
            end
            c_st_out: begin
                if (w_handshake) begin
                    w_next_state = (r_k == c_last_idx) ? c_st_done : c_st_run;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // FSM: outputs
    //------------------------------------------------------------------------
    always_comb begin
        busy       = (r_state != c_st_idle);
        done       = (r_state == c_st_done);
        pix_addr   = r_n;
        n1         = r_n[5:3];
        n2         = r_n[2:0];
        k1         = r_k[5:3];
        k2         = r_k[2:0];
        coef_valid = r_coef_valid;
        coef_addr  = r_coef_addr;
        coef_data  = r_coef_data;
    end

    //------------------------------------------------------------------------
    // Datapath control and arithmetic
    //------------------------------------------------------------------------
    always_comb begin
        w_handshake = (r_state == c_st_out) && r_coef_valid && coef_ready;
        w_start_ok  = (r_state == c_st_idle) && start;
    end

    // Both operands sign-extended to 40 bits; the low 40 bits of the
    // product are the exact signed 8x32 result.
    always_comb begin
        w_prod = {{32{pix_data[7]}}, pix_data} * {{8{r_cos[31]}}, r_cos};
    end

    // The final stage-3 add lands on the same edge that enters OUT, so the
    // output coefficient is taken from the next accumulator value.
    always_comb begin
        w_acc_next = r_acc;
        if (r_s2_valid) begin
            w_acc_next = r_acc + {{8{r_prod[39]}}, r_prod};
        end
        w_shift = w_acc_next >>> FRAC_BITS;
        if (w_shift > c_sat_max) begin
            w_sat = 32'h7FFF_FFFF;
        end else if (w_shift < c_sat_min) begin
            w_sat = 32'h8000_0000;
        end else begin
            w_sat = w_shift[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n          <= '0;
            r_k          <= '0;
            r_drain      <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_cos        <= '0;
            r_s2_valid   <= 1'b0;
            r_prod       <= '0;
            r_acc        <= '0;
            r_coef_valid <= 1'b0;
            r_coef_addr  <= '0;
            r_coef_data  <= '0;
        end else begin
            // Sample index is zero outside RUN and wraps to zero on exit.
            if (r_state == c_st_run) begin
                r_n <= r_n + 6'd1;
            end else begin
                r_n <= '0;
            end

            if (r_state == c_st_drain) begin
                r_drain <= ~r_drain;
            end else begin
                r_drain <= 1'b0;
            end

            if (w_start_ok) begin
                r_k <= '0;
            end else if (w_handshake && (r_k != c_last_idx)) begin
                r_k <= r_k + 6'd1;
            end

            r_s1_valid <= (r_state == c_st_run);
            r_cos      <= cos_term;
            r_s2_valid <= r_s1_valid;
            r_prod     <= w_prod;

            if (w_start_ok || w_handshake) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_next;
            end

            if ((r_state == c_st_drain) && r_drain) begin
                r_coef_valid <= 1'b1;
                r_coef_addr  <= r_k;
                r_coef_data  <= w_sat;
            end else if (w_handshake) begin
                r_coef_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_mac_sequencer.sv
`default_nettype none
//============================================================================
// Module : tb_dct_mac_sequencer
// Brief  : Self-checking bench for dct_mac_sequencer with a cosine LUT bank
//          model, a pixel RAM model and a coefficient scoreboard.
// Rev    : 1.0  initial release
//============================================================================
module tb_dct_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  pix_addr;
    logic [7:0]  pix_data;
    logic [2:0]  k1;
    logic [2:0]  k2;
    logic [2:0]  n1;
    logic [2:0]  n2;
    logic [31:0] cos_term;
    logic        coef_valid;
    logic        coef_ready;
    logic [5:0]  coef_addr;
    logic [31:0] coef_data;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic signed [7:0] pix_mem [64];
    int                cos_tab [4096];
    logic              cos_max_mode = 1'b0;
    logic [31:0]       got_data [64];
    int                n_coef = 0;
    logic [5:0]        first_addr;
    int                cyc = 0;
    int                n_tests = 0;
    int                n_fail = 0;

    dct_mac_sequencer #(.FRAC_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .k1         (k1),
        .k2         (k2),
        .n1         (n1),
        .n2         (n2),
        .cos_term   (cos_term),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data)
    );

    always #5 clk = ~clk;

    // Pixel RAM: one-cycle read latency.
    always_ff @(posedge clk) pix_data <= pix_mem[pix_addr];

    // Cosine LUT bank selected by (k1,k2), indexed by (n1,n2).
    always_comb begin
        cos_term = cos_max_mode ? 32'h7FFF_FFFF : cos_tab[{k1, k2, n1, n2}];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: pop and compare on every coefficient handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && coef_valid && coef_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL coef_unexpected: got addr %0d data %h, required no coefficient", coef_addr, coef_data);
            end else begin
                e = exp_q.pop_front();
                if (coef_addr !== e.addr || coef_data !== e.data) begin
                    n_fail++;
                    $display("FAIL coef_value: got addr %0d data %h, required addr %0d data %h",
                             coef_addr, coef_data, e.addr, e.data);
                end
            end
            if (n_coef == 0) first_addr = coef_addr;
            got_data[coef_addr] = coef_data;
            n_coef++;
        end
    end

    function automatic void build_cos_table();
        real pi = 3.14159265358979323846;
        for (int i = 0; i < 4096; i++) begin
            real c1, c2, v;
            int  a1, a2, b1, b2;
            a1 = (i >> 9) & 7;
            a2 = (i >> 6) & 7;
            b1 = (i >> 3) & 7;
            b2 = i & 7;
            c1 = $cos(real'((2 * b1 + 1) * a1) * pi / 16.0);
            c2 = $cos(real'((2 * b2 + 1) * a2) * pi / 16.0);
            v  = 256.0 * c1 * c2;
            cos_tab[i] = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        end
    endfunction

    function automatic void push_expected();
        for (int k = 0; k < 64; k++) begin
            longint      sum;
            longint      s;
            longint      cv;
            logic [31:0] d;
            exp_t        e;
            sum = 0;
            for (int n = 0; n < 64; n++) begin
                cv  = cos_max_mode ? 64'sh7FFF_FFFF : longint'(cos_tab[k * 64 + n]);
                sum = sum + longint'(pix_mem[n]) * cv;
            end
            s = sum >>> 8;
            if (s > 64'sh7FFF_FFFF)        d = 32'h7FFF_FFFF;
            else if (s < -64'sh8000_0000)  d = 32'h8000_0000;
            else                           d = s[31:0];
            e.addr = k[5:0];
            e.data = d;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void fill_pixels(input int value);
        for (int n = 0; n < 64; n++) pix_mem[n] = value[7:0];
    endfunction

    task automatic pulse_start(output int c0);
        @(posedge clk); #1;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int done_rel, output int first_rel);
        done_rel  = -1;
        first_rel = -1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (coef_valid && first_rel < 0) first_rel = cyc - c0;
            if (done) begin
                done_rel = cyc - c0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; coef_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got busy %b done %b, required 0 0", busy, done);
        end
        n_tests++;
        if (coef_valid !== 1'b0 || coef_addr !== 6'd0 || coef_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_coef: got valid %b addr %0d data %h, required 0 0 0", coef_valid, coef_addr, coef_data);
        end
        n_tests++;
        if (pix_addr !== 6'd0 || {k1, k2, n1, n2} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_index: got pix_addr %0d k/n %h, required 0 0", pix_addr, {k1, k2, n1, n2});
        end
    endtask

    task automatic test_zero_pixels();
        int c0, dr, fr;
        fill_pixels(0); cos_max_mode = 1'b0; coef_ready = 1'b1; n_coef = 0;
        push_expected();
        pulse_start(c0);
        wait_done(c0, dr, fr);
        n_tests++;
        if (fr != 67) begin
            n_fail++;
            $display("FAIL zero_first_valid: got cycle c+%0d, required c+67", fr);
        end
        n_tests++;
        if (dr != 4289) begin
            n_fail++;
            $display("FAIL zero_done_time: got cycle c+%0d, required c+4289", dr);
        end
        n_tests++;
        if (n_coef != 64 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_count: got %0d coefs %0d pending, required 64 0", n_coef, exp_q.size());
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after_done: got done %b busy %b, required 0 0", done, busy);
        end
    endtask

    task automatic test_pixel00();
        int c0, dr, fr;
        bit bad;
        fill_pixels(0); pix_mem[0] = 8'sd100; n_coef = 0;
        push_expected();
        pulse_start(c0);
        bad = 1'b0;
        for (int r = 1; r <= 64; r++) begin
            @(negedge clk);
            if (pix_addr !== 6'(cyc - c0 - 1) || n1 !== pix_addr[5:3] || n2 !== pix_addr[2:0]) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL run_addr_seq: got out-of-order pix_addr/n1/n2, required 0..63 in order");
        end
        wait_done(c0, dr, fr);
        n_tests++;
        if (got_data[41] !== 32'd54) begin
            n_fail++;
            $display("FAIL pix00_coef41: got %h, required %h", got_data[41], 32'd54);
        end
        n_tests++;
        if (dr != 4289) begin
            n_fail++;
            $display("FAIL pix00_done_time: got c+%0d, required c+4289", dr);
        end
    endtask

    task automatic test_pixel10_floor();
        int c0, dr, fr;
        fill_pixels(0); pix_mem[8] = 8'sd100; n_coef = 0;
        push_expected();
        pulse_start(c0);
        wait_done(c0, dr, fr);
        n_tests++;
        if (got_data[41] !== 32'hFFFF_FF9F) begin
            n_fail++;
            $display("FAIL pix10_coef41: got %h, required %h", got_data[41], 32'hFFFF_FF9F);
        end
    endtask

    task automatic test_stall();
        int c0, dr, fr, rel;
        logic [5:0]  a0;
        logic [31:0] d0;
        bit bad;
        n_coef = 0; coef_ready = 1'b0;
        push_expected();
        pulse_start(c0);
        rel = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (coef_valid) begin
                rel = cyc - c0;
                break;
            end
        end
        n_tests++;
        if (rel != 67) begin
            n_fail++;
            $display("FAIL stall_first_valid: got c+%0d, required c+67", rel);
        end
        a0 = coef_addr; d0 = coef_data; bad = 1'b0;
        for (int j = 1; j < 10; j++) begin
            @(negedge clk);
            if (coef_valid !== 1'b1 || coef_addr !== a0 || coef_data !== d0 || pix_addr !== 6'd0 ||
                n1 !== 3'd0 || n2 !== 3'd0 || {k1, k2} !== 6'd0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL stall_hold: got changing coef/addr while ready low, required stable with pix_addr 0");
        end
        @(posedge clk); #1 coef_ready = 1'b1;
        wait_done(c0, dr, fr);
        n_tests++;
        if (dr != 4299) begin
            n_fail++;
            $display("FAIL stall_done_time: got c+%0d, required c+4299", dr);
        end
    endtask

    task automatic test_sat_max();
        int c0, dr, fr;
        bit bad;
        fill_pixels(127); cos_max_mode = 1'b1; n_coef = 0;
        push_expected();
        pulse_start(c0);
        wait_done(c0, dr, fr);
        bad = 1'b0;
        for (int k = 0; k < 64; k++) if (got_data[k] !== 32'h7FFF_FFFF) bad = 1'b1;
        n_tests++;
        if (bad || n_coef != 64) begin
            n_fail++;
            $display("FAIL sat_max: got coef0 %h count %0d, required 7fffffff 64", got_data[0], n_coef);
        end
    endtask

    task automatic test_back_to_back();
        int c0, dr, fr;
        fill_pixels(-128); cos_max_mode = 1'b1; n_coef = 0;
        push_expected();
        @(posedge clk); #1;
        start = 1'b1;
        c0 = cyc;
        wait_done(c0, dr, fr);
        n_tests++;
        if (dr != 4289 || got_data[63] !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL sat_min: got done c+%0d coef63 %h, required c+4289 80000000", dr, got_data[63]);
        end
        push_expected();
        n_coef = 0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy %b done %b, required 0 0", busy, done);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || pix_addr !== 6'd0 || {k1, k2} !== 6'd0) begin
            n_fail++;
            $display("FAIL b2b_relaunch: got busy %b pix_addr %0d k %0d, required 1 0 0", busy, pix_addr, {k1, k2});
        end
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int c0, dr, fr;
        bit found, bad;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ({k1, k2} == 6'd20 && pix_addr == 6'd10) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_reach_k20: got no RUN of coefficient 20, required one");
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || coef_valid !== 1'b0 || done !== 1'b0 || {k1, k2} !== 6'd0 || pix_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_midrun: got busy %b valid %b done %b k %0d pix %0d, required 0 0 0 0 0",
                     busy, coef_valid, done, {k1, k2}, pix_addr);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_no_done: got done/busy activity after reset, required none");
        end
        n_tests++;
        if (exp_q.size() != 44) begin
            n_fail++;
            $display("FAIL reset_popped: got %0d pending, required 44", exp_q.size());
        end
        exp_q.delete();
        cos_max_mode = 1'b0;
        for (int n = 0; n < 64; n++) pix_mem[n] = 8'($urandom_range(255));
        n_coef = 0;
        push_expected();
        pulse_start(c0);
        wait_done(c0, dr, fr);
        n_tests++;
        if (first_addr !== 6'd0 || dr != 4289 || n_coef != 64) begin
            n_fail++;
            $display("FAIL restart: got first addr %0d done c+%0d count %0d, required 0 c+4289 64",
                     first_addr, dr, n_coef);
        end
    endtask

    initial begin
        build_cos_table();
        fill_pixels(0);
        test_reset();
        test_zero_pixels();
        test_pixel00();
        test_pixel10_floor();
        test_stall();
        test_sat_max();
        test_back_to_back();
        test_reset_mid_run();
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
